// File: rtl/match_sequencer_if.sv
// Signal bundle between the match sequencer and its surroundings
// (start button, ball controller, score display).
interface match_sequencer_if;
    logic       start_button;
    logic       score_to_team1;
    logic       score_to_team2;
    logic       ball_enable;
    logic       ball_restart;
    logic       serve_dir;
    logic [3:0] team1_points;
    logic [3:0] team2_points;
    logic [1:0] winner;
    logic [2:0] state_out;

    // master: the sequencer itself; slave: ball controller, button and display side
    modport master (
        input  start_button, score_to_team1, score_to_team2,
        output ball_enable, ball_restart, serve_dir,
               team1_points, team2_points, winner, state_out
    );

    modport slave (
        output start_button, score_to_team1, score_to_team2,
        input  ball_enable, ball_restart, serve_dir,
               team1_points, team2_points, winner, state_out
    );
endinterface

// File: rtl/match_sequencer.sv
// Game-flow controller: idle, serve countdown, live play, post-goal pause and
// game over. Keeps the score and gates/recentres the ball.
module match_sequencer #(
    parameter int WIN_SCORE   = 7,
    parameter int SERVE_DELAY = 50000000,
    parameter int PAUSE_DELAY = 100000000,
    parameter int CNT_WIDTH   = 27
) (
    input  logic               clk,
    input  logic               rst,
    match_sequencer_if.master  bus
);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] SERVE      = 3'd1;
    localparam logic [2:0] PLAY       = 3'd2;
    localparam logic [2:0] GOAL_PAUSE = 3'd3;
    localparam logic [2:0] GAME_OVER  = 3'd4;

    // The delay counter is loaded with DELAY-1 and leaves its state on reaching 0.
    localparam logic [CNT_WIDTH-1:0] SERVE_LOAD = CNT_WIDTH'(SERVE_DELAY - 1);
    localparam logic [CNT_WIDTH-1:0] PAUSE_LOAD = CNT_WIDTH'(PAUSE_DELAY - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);
    localparam logic [3:0]           WIN_PTS    = 4'(WIN_SCORE);

    logic [2:0]           state, state_d;
    logic [CNT_WIDTH-1:0] cnt, cnt_d;
    logic [3:0]           t1_pts, t1_pts_d, t2_pts, t2_pts_d;
    logic [1:0]           win, win_d;
    logic                 dir, dir_d;
    logic                 restart, restart_d;
    logic                 enable;
    logic                 start_q, s1_q, s2_q;

    logic start_rise, goal1, goal2;
    logic [3:0] t1_inc, t2_inc;

    assign start_rise = bus.start_button & ~start_q;
    assign goal1      = bus.score_to_team1 & ~s1_q;
    assign goal2      = bus.score_to_team2 & ~s2_q;

    // Saturating increments; a legal WIN_SCORE ends the game before 15.
    assign t1_inc = (t1_pts == 4'hF) ? t1_pts : t1_pts + 4'd1;
    assign t2_inc = (t2_pts == 4'hF) ? t2_pts : t2_pts + 4'd1;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
        state_d   = state;
        cnt_d     = cnt;
        t1_pts_d  = t1_pts;
        t2_pts_d  = t2_pts;
        win_d     = win;
        dir_d     = dir;
        restart_d = 1'b0;

        case (state)
            IDLE, GAME_OVER: begin
                if (start_rise) begin
                    state_d   = SERVE;
                    cnt_d     = SERVE_LOAD;
                    t1_pts_d  = 4'd0;
                    t2_pts_d  = 4'd0;
                    win_d     = 2'b00;
                    restart_d = 1'b1;
                end
            end

            SERVE: begin
                if (cnt == '0) state_d = PLAY;
                else           cnt_d   = cnt - CNT_ONE;
            end

            PLAY: begin
                if (goal1 || goal2) begin
                    state_d = GOAL_PAUSE;
                    cnt_d   = PAUSE_LOAD;
                    // Simultaneous goals cancel out: pause, but no point and no serve change.
                    if (goal1 && !goal2) begin
                        t1_pts_d = t1_inc;
                        dir_d    = 1'b0;
                        if (t1_inc == WIN_PTS) begin
                            state_d = GAME_OVER;
                            win_d   = 2'b01;
                        end
                    end else if (goal2 && !goal1) begin
                        t2_pts_d = t2_inc;
                        dir_d    = 1'b1;
                        if (t2_inc == WIN_PTS) begin
                            state_d = GAME_OVER;
                            win_d   = 2'b10;
                        end
                    end
                end
            end

            GOAL_PAUSE: begin
                if (cnt == '0) begin
                    state_d   = SERVE;
                    cnt_d     = SERVE_LOAD;
                    restart_d = 1'b1;
                end else begin
                    cnt_d = cnt - CNT_ONE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every register samples the pre-edge values.
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            t1_pts  <= 4'd0;
            t2_pts  <= 4'd0;
            win     <= 2'b00;
            dir     <= 1'b0;
            restart <= 1'b0;
            enable  <= 1'b0;
            start_q <= 1'b0;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            t1_pts  <= t1_pts_d;
            t2_pts  <= t2_pts_d;
            win     <= win_d;
            dir     <= dir_d;
            restart <= restart_d;
            // Registered from the next state so the ball moves on the very first PLAY cycle.
            enable  <= (state_d == PLAY);
            start_q <= bus.start_button;
            s1_q    <= bus.score_to_team1;
            s2_q    <= bus.score_to_team2;
        end
    end

    assign bus.ball_enable  = enable;
    assign bus.ball_restart = restart;
    assign bus.serve_dir    = dir;
    assign bus.team1_points = t1_pts;
    assign bus.team2_points = t2_pts;
    assign bus.winner       = win;
    assign bus.state_out    = state;

endmodule
